// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_ctrl_pkg
// Description : Shared types and default constants for the radix-2 SDF FFT
//               stage sequencer (FSM state encoding, per-beat flag bundle).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fft_ctrl_pkg;

  // Default geometry: 17-cycle delay line (16 regs + output reg),
  // 32 beats of 16 samples (512 points), butterfly span of 16 beats.
  localparam int C_DELAY = 17;
  localparam int C_BEATS = 32;
  localparam int C_HALF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eof;
  } beat_flags_t;

endpackage : fft_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_flag_delay.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_flag_delay
// Description : DELAY-deep shift register of {valid,sof,eof} beat flags that
//               tracks the data delay line cycle for cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flags_in        - flags of the beat entering the delay line
//               flags_out       - flags of the beat leaving the delay line
//               any_valid       - some stage holds a valid beat
//               keep_valid      - a valid beat will still be held after the
//                                 next shift (ignores the final stage)
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_flag_delay
  import fft_ctrl_pkg::*;
#(
  parameter int DELAY = C_DELAY
) (
  input  logic        clk,
  input  logic        rst,
  input  beat_flags_t flags_in,
  output beat_flags_t flags_out,
  output logic        any_valid,
  output logic        keep_valid
);

  beat_flags_t stage_q [DELAY];
  beat_flags_t stage_d [DELAY];

  always_comb begin
    stage_d[0] = flags_in;
    for (int i = 1; i < DELAY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  // keep_valid looks only at stages that survive the next shift, so the
  // controller can leave DRAIN in the same cycle the last beat emerges.
  always_comb begin
    any_valid  = 1'b0;
    keep_valid = 1'b0;
    for (int i = 0; i < DELAY; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
    for (int i = 0; i < DELAY - 1; i++) begin
      keep_valid = keep_valid | stage_q[i].valid;
    end
  end

  assign flags_out = stage_q[DELAY-1];

endmodule : ctrl_flag_delay
`default_nettype wire

// File: rtl/fft_dly_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_dly_stage_ctrl
// Description : Sequencer for one radix-2 SDF FFT stage around a 16-lane I/Q
//               delay line. Counts beats per frame, drives butterfly select
//               and twiddle index, tracks valid/sof/eof through the delay
//               line latency and flags frame-integrity errors.
// Ports       : clk, rst                  - clock, sync active-high reset
//               in_valid, in_sof, in_eof  - beat qualifiers at line input
//               bfly_sel, tw_idx          - butterfly select / twiddle index
//               dly_valid, dly_sof        - delayed beat qualifiers
//               frame_done                - pulse when delayed eof emerges
//               busy                      - frame or flags in flight
//               err_gap, err_len          - sticky integrity errors
// Revision    : 1.0 - initial release
// ============================================================================
module fft_dly_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DELAY = C_DELAY,
  parameter int BEATS = C_BEATS,
  parameter int HALF  = C_HALF,
  parameter int TW_W  = $clog2(HALF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic            in_eof,
  output logic            bfly_sel,
  output logic [TW_W-1:0] tw_idx,
  output logic            dly_valid,
  output logic            dly_sof,
  output logic            frame_done,
  output logic            busy,
  output logic            err_gap,
  output logic            err_len
);

  localparam int               CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int               SEL_BIT = $clog2(HALF);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(BEATS - 1);

  ctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic            bfly_sel_q, bfly_sel_d;
  logic [TW_W-1:0] tw_idx_q, tw_idx_d;
  logic            err_gap_q, err_gap_d;
  logic            err_len_q, err_len_d;

  logic [CNT_W-1:0] beat_idx;
  logic             accept;
  beat_flags_t      flags_in, flags_out;
  logic             pipe_any, pipe_keep;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    bfly_sel_d = bfly_sel_q;
    tw_idx_d   = tw_idx_q;
    err_gap_d  = err_gap_q;
    err_len_d  = err_len_q;
    accept     = 1'b0;
    beat_idx   = beat_cnt_q;

    // sof always wins: it (re)starts the frame from any state, and a
    // restart in the middle of a running frame is a length error.
    if (in_valid) begin
      if (in_sof) begin
        accept   = 1'b1;
        beat_idx = '0;
        if (state_q == RUN && beat_cnt_q != '0) begin
          err_len_d = 1'b1;
        end
      end else if (state_q == RUN) begin
        accept = 1'b1;
      end
    end else if (state_q == RUN) begin
      // The delay line cannot stall, so a hole inside a frame is fatal
      // to the data; the count simply holds.
      err_gap_d = 1'b1;
    end

    if (accept) begin
      bfly_sel_d = beat_idx[SEL_BIT];
      tw_idx_d   = beat_idx[SEL_BIT] ? beat_idx[TW_W-1:0] : '0;
      if (in_eof || beat_idx == LAST) begin
        if (!(in_eof && beat_idx == LAST)) begin
          err_len_d = 1'b1;
        end
        state_d    = DRAIN;
        beat_cnt_d = '0;
      end else begin
        state_d    = RUN;
        beat_cnt_d = beat_idx + CNT_W'(1);
      end
    end else if (state_q == DRAIN && !pipe_keep) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      bfly_sel_q <= 1'b0;
      tw_idx_q   <= '0;
      err_gap_q  <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      bfly_sel_q <= bfly_sel_d;
      tw_idx_q   <= tw_idx_d;
      err_gap_q  <= err_gap_d;
      err_len_q  <= err_len_d;
    end
  end

  // Only accepted beats enter the flag pipeline; stray beats never
  // produce dly_valid or keep the block busy.
  always_comb begin
    flags_in.valid = accept;
    flags_in.sof   = accept & in_sof;
    flags_in.eof   = accept & in_eof;
  end

  ctrl_flag_delay #(
    .DELAY (DELAY)
  ) u_flag_delay (
    .clk        (clk),
    .rst        (rst),
    .flags_in   (flags_in),
    .flags_out  (flags_out),
    .any_valid  (pipe_any),
    .keep_valid (pipe_keep)
  );

  assign bfly_sel   = bfly_sel_q;
  assign tw_idx     = tw_idx_q;
  assign dly_valid  = flags_out.valid;
  assign dly_sof    = flags_out.valid & flags_out.sof;
  assign frame_done = flags_out.valid & flags_out.eof;
  assign busy       = (state_q != IDLE) | pipe_any;
  assign err_gap    = err_gap_q;
  assign err_len    = err_len_q;

endmodule : fft_dly_stage_ctrl
`default_nettype wire

// File: tb/tb_fft_dly_stage_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fft_dly_stage_ctrl
// Description : Self-checking bench for fft_dly_stage_ctrl. A frame-level
//               reference model records which beats were accepted per cycle
//               and derives every output from that history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_dly_stage_ctrl;

  localparam int DELAY = 17;
  localparam int BEATS = 32;
  localparam int HALF  = 16;
  localparam int TW_W  = 4;
  localparam int NH    = 8192;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_sof = 1'b0;
  logic            in_eof = 1'b0;
  logic            bfly_sel;
  logic [TW_W-1:0] tw_idx;
  logic            dly_valid, dly_sof, frame_done, busy, err_gap, err_len;

  fft_dly_stage_ctrl #(
    .DELAY (DELAY),
    .BEATS (BEATS),
    .HALF  (HALF),
    .TW_W  (TW_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_eof     (in_eof),
    .bfly_sel   (bfly_sel),
    .tw_idx     (tw_idx),
    .dly_valid  (dly_valid),
    .dly_sof    (dly_sof),
    .frame_done (frame_done),
    .busy       (busy),
    .err_gap    (err_gap),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: per-cycle record of accepted beats plus frame position.
  bit acc_v [NH];
  bit acc_s [NH];
  bit acc_e [NH];
  bit m_in_frame = 1'b0;
  int m_pos      = 0;
  bit m_bfly     = 1'b0;
  int m_tw       = 0;
  bit m_gap      = 1'b0;
  bit m_len      = 1'b0;

  function automatic void model_step(input bit v, input bit s, input bit e, input bit r);
    int idx;
    bit acc;
    acc_v[cyc] = 1'b0;
    acc_s[cyc] = 1'b0;
    acc_e[cyc] = 1'b0;
    if (r) begin
      for (int k = 0; k <= cyc; k++) begin
        acc_v[k] = 1'b0;
      end
      m_in_frame = 1'b0; m_pos = 0; m_bfly = 1'b0; m_tw = 0; m_gap = 1'b0; m_len = 1'b0;
      return;
    end
    acc = 1'b0;
    idx = m_pos;
    if (v) begin
      if (s) begin
        acc = 1'b1;
        if (m_in_frame && m_pos != 0) m_len = 1'b1;
        idx = 0;
      end else if (m_in_frame) begin
        acc = 1'b1;
      end
    end else if (m_in_frame) begin
      m_gap = 1'b1;
    end
    if (acc) begin
      acc_v[cyc] = 1'b1;
      acc_s[cyc] = s;
      acc_e[cyc] = e;
      m_bfly = ((idx / HALF) % 2) == 1;
      m_tw   = m_bfly ? (idx % HALF) : 0;
      if (e != (idx == BEATS - 1)) m_len = 1'b1;
      if (e || idx == BEATS - 1) begin
        m_in_frame = 1'b0;
        m_pos      = 0;
      end else begin
        m_in_frame = 1'b1;
        m_pos      = idx + 1;
      end
    end
  endfunction

  function automatic logic [11:0] exp_vec();
    bit dv, ds, fd, bz;
    dv = 1'b0; ds = 1'b0; fd = 1'b0;
    if (cyc >= DELAY) begin
      dv = acc_v[cyc-DELAY];
      ds = dv && acc_s[cyc-DELAY];
      fd = dv && acc_e[cyc-DELAY];
    end
    bz = m_in_frame;
    for (int k = cyc - DELAY; k < cyc; k++) begin
      if (k >= 0 && acc_v[k]) bz = 1'b1;
    end
    return {m_bfly, 4'(m_tw), dv, ds, fd, bz, m_gap, m_len};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bfly_sel, tw_idx, dly_valid, dly_sof, frame_done, busy, err_gap, err_len};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1ns.
  task automatic tick(input bit v, input bit s, input bit e, input bit r);
    rst = r; in_valid = v; in_sof = s; in_eof = e;
    @(posedge clk);
    model_step(v, s, e, r);
    cyc++;
    #1;
  endtask

  task automatic start_clean();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [11:0] o, x;
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    o = dut_vec();
    n_cmp++;
    if (o !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=%b", o, 12'h000);
    end
    for (int i = 0; i < 8; i++) begin
      tick(i >= 2 && i < 5, 1'b0, i == 4, 0);
      o = dut_vec(); x = exp_vec();
      n_cmp++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL idle_stray cyc=%0d got=%b want=%b", cyc, o, x);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_busy cyc=%0d got=%b want=0", cyc, busy);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [11:0] o, x;
    int t0, rel;
    start_clean();
    t0 = cyc;
    for (int t = 0; t < 56; t++) begin
      tick(t < BEATS, t == 0, t == BEATS - 1, 0);
      rel = cyc - t0;
      o = dut_vec(); x = exp_vec();
      n_cmp++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL single_model rel=%0d got=%b want=%b", rel, o, x);
      end
      n_cmp++;
      if (dly_valid !== (rel >= 17 && rel <= 48) || frame_done !== (rel == 48) ||
          dly_sof !== (rel == 17) || busy !== (rel <= 48) || err_gap !== 1'b0 || err_len !== 1'b0) begin
        n_fail++;
        $display("FAIL single_flags rel=%0d got dv=%b ds=%b fd=%b busy=%b eg=%b el=%b", rel,
                 dly_valid, dly_sof, frame_done, busy, err_gap, err_len);
      end
      if (rel >= 1 && rel <= 32) begin
        n_cmp++;
        if (bfly_sel !== (rel >= 17) || tw_idx !== ((rel >= 17) ? 4'(rel - 17) : 4'd0)) begin
          n_fail++;
          $display("FAIL single_sel rel=%0d got sel=%b tw=%0d", rel, bfly_sel, tw_idx);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] o, x;
    int t0, rel;
    start_clean();
    t0 = cyc;
    for (int t = 0; t < 90; t++) begin
      tick(t < 2 * BEATS, t == 0 || t == BEATS, t == BEATS - 1 || t == 2 * BEATS - 1, 0);
      rel = cyc - t0;
      o = dut_vec(); x = exp_vec();
      n_cmp++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL b2b_model rel=%0d got=%b want=%b", rel, o, x);
      end
      n_cmp++;
      if (dly_valid !== (rel >= 17 && rel <= 80) || frame_done !== (rel == 48 || rel == 80) ||
          err_gap !== 1'b0 || err_len !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_flags rel=%0d got dv=%b fd=%b eg=%b el=%b", rel, dly_valid, frame_done, err_gap, err_len);
      end
    end
  endtask

  task automatic test_gap();
    logic [11:0] o, x;
    int t0, rel;
    start_clean();
    t0 = cyc;
    for (int t = 0; t < 60; t++) begin
      tick(t <= BEATS && t != 10, t == 0, t == BEATS, 0);
      rel = cyc - t0;
      o = dut_vec(); x = exp_vec();
      n_cmp++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL gap_model rel=%0d got=%b want=%b", rel, o, x);
      end
      n_cmp++;
      if (err_gap !== (rel >= 11) || err_len !== 1'b0 || frame_done !== (rel == 49)) begin
        n_fail++;
        $display("FAIL gap_flags rel=%0d got eg=%b el=%b fd=%b", rel, err_gap, err_len, frame_done);
      end
      if (rel == 17 || rel == 18) begin
        n_cmp++;
        if (bfly_sel !== (rel == 18)) begin
          n_fail++;
          $display("FAIL gap_resume rel=%0d got sel=%b want=%b", rel, bfly_sel, rel == 18);
        end
      end
    end
  endtask

  task automatic test_short_frame();
    logic [11:0] o, x;
    int t0, rel;
    bit v, s, e;
    start_clean();
    t0 = cyc;
    for (int t = 0; t < 80; t++) begin
      v = (t <= 20) || (t >= 25 && t < 25 + BEATS);
      s = (t == 0) || (t == 25);
      e = (t == 20) || (t == 25 + BEATS - 1);
      tick(v, s, e, 0);
      rel = cyc - t0;
      o = dut_vec(); x = exp_vec();
      n_cmp++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL short_model rel=%0d got=%b want=%b", rel, o, x);
      end
      n_cmp++;
      if (err_len !== (rel >= 21) || err_gap !== 1'b0 || frame_done !== (rel == 37 || rel == 73)) begin
        n_fail++;
        $display("FAIL short_flags rel=%0d got el=%b eg=%b fd=%b", rel, err_len, err_gap, frame_done);
      end
      if (rel == 26) begin
        n_cmp++;
        if (bfly_sel !== 1'b0 || tw_idx !== 4'd0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL short_restart rel=%0d got sel=%b tw=%0d busy=%b", rel, bfly_sel, tw_idx, busy);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] o, x;
    int t0, rel;
    start_clean();
    t0 = cyc;
    for (int t = 0; t < 60; t++) begin
      tick(t <= 25, t == 0, 1'b0, t == 25);
      rel = cyc - t0;
      o = dut_vec(); x = exp_vec();
      n_cmp++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL rst_model rel=%0d got=%b want=%b", rel, o, x);
      end
      if (rel >= 26) begin
        n_cmp++;
        if (o !== 12'h000) begin
          n_fail++;
          $display("FAIL rst_clear rel=%0d got=%b want=%b", rel, o, 12'h000);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] o, x;
    bit v, s, e, r, gin;
    int gpos;
    gin = 1'b0; gpos = 0;
    start_clean();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom % 300) == 0;
      v = ($urandom % 40) != 0;
      s = 1'b0; e = 1'b0;
      if (v) begin
        if (!gin) begin
          s = ($urandom % 3) == 0;
          if (s) begin gin = 1'b1; gpos = 0; end
          else e = ($urandom % 4) == 0;
        end else if (($urandom % 150) == 0) begin
          s = 1'b1; gpos = 0;
        end
        if (gin) begin
          e = (gpos == BEATS - 1) ? (($urandom % 40) != 0) : (($urandom % 200) == 0);
          if (e || gpos == BEATS - 1) begin gin = 1'b0; gpos = 0; end
          else gpos++;
        end
      end
      if (r) begin gin = 1'b0; gpos = 0; end
      tick(v, s, e, r);
      o = dut_vec(); x = exp_vec();
      n_cmp++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, o, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_short_frame();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fft_dly_stage_ctrl
`default_nettype wire
